audio_cfg_seq: RTL

AUDIO_CFG_SEQ -- requirements
Module: audio_cfg_seq

---
 rtl/audio_cfg_seq_if.sv | 12 +
 rtl/audio_cfg_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/audio_cfg_seq_if.sv
// Shadow-register write bus of the audio coefficient sequencer:
// byte writes, commit request and the busy status returned to the host.
interface audio_cfg_seq_if;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       commit;
    logic       busy;

    modport master (output wr, addr, wdata, commit, input busy);
    modport slave  (input wr, addr, wdata, commit, output busy);
endinterface

// File: rtl/audio_cfg_seq.sv
// Audio filter coefficient sequencer: a host writes a shadow coefficient set
// byte by byte; a commit fades the output attenuation up to 16, swaps the
// shadow set into the active set, waits for the filter to settle and then
// fades back down to the user attenuation.
module audio_cfg_seq #(
    parameter int unsigned        STEP_SAMPLES   = 64,
    parameter int unsigned        SETTLE_SAMPLES = 256,
    parameter logic [31:0]        DEF_FLT_RATE   = 32'd7056000,
    parameter logic [39:0]        DEF_CX         = 40'd4258969,
    parameter logic [7:0]         DEF_CX0        = 8'd3,
    parameter logic [7:0]         DEF_CX1        = 8'd3,
    parameter logic [7:0]         DEF_CX2        = 8'd1,
    parameter logic signed [23:0] DEF_CY0        = -24'sd6216759,
    parameter logic signed [23:0] DEF_CY1        = 24'sd6143386,
    parameter logic signed [23:0] DEF_CY2        = -24'sd2023767
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_ce,
    audio_cfg_seq_if.slave bus,
    input  logic [4:0]  user_att,
    input  logic [1:0]  user_mix,
    output logic [31:0] flt_rate,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2,
    output logic [4:0]  att,
    output logic [1:0]  mix
);

    // Byte n of the set lives at bits [8n+7:8n]; 21 bytes in total.
    localparam logic [167:0] DEF_SET = {DEF_CY2, DEF_CY1, DEF_CY0,
                                        DEF_CX2, DEF_CX1, DEF_CX0,
                                        DEF_CX, DEF_FLT_RATE};

    localparam int unsigned CNT_TOP = (STEP_SAMPLES > SETTLE_SAMPLES) ?
                                      STEP_SAMPLES : SETTLE_SAMPLES;
    localparam int unsigned CW      = $clog2(CNT_TOP + 1);
    localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_SAMPLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_SAMPLES - 1);
    localparam logic [4:0]    ATT_MUTE    = 5'd16;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_DOWN,
        SWAP,
        SETTLE,
        RAMP_UP
    } state_t;

    state_t         state;
    logic           pending;
    logic [CW-1:0]  cnt;
    logic [167:0]   shadow;
    logic [167:0]   active;

    // Host byte writes land in the shadow set in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= DEF_SET;
        end else if (bus.wr && (bus.addr < 5'd21)) begin
            shadow[{bus.addr, 3'b000} +: 8] <= bus.wdata;
        end
    end

    // Fade/swap/settle sequencer; also owns att, mix and the active set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= 1'b0;
            cnt     <= '0;
            att     <= ATT_MUTE;
            mix     <= '0;
            active  <= DEF_SET;
        end else begin
            // A commit arriving mid-sequence is remembered and replayed
            // from IDLE; several such commits collapse into one.
            if (bus.commit && (state != IDLE)) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    att <= user_att;
                    mix <= user_mix;
                    cnt <= '0;
                    if (bus.commit || pending) begin
                        state   <= RAMP_DOWN;
                        pending <= 1'b0;
                    end
                end

                RAMP_DOWN: begin
                    if (att >= ATT_MUTE) begin
                        state <= SWAP;
                        cnt   <= '0;
                    end else if (sample_ce) begin
                        if (cnt == STEP_LAST) begin
                            cnt <= '0;
                            att <= att + 5'd1;
                            if (att == ATT_MUTE - 5'd1) begin
                                state <= SWAP;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                SWAP: begin
                    active <= shadow;
                    att    <= ATT_MUTE;
                    cnt    <= '0;
                    state  <= SETTLE;
                end

                SETTLE: begin
                    if (sample_ce) begin
                        if (cnt == SETTLE_LAST) begin
                            cnt   <= '0;
                            state <= RAMP_UP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                RAMP_UP: begin
                    if (user_att >= att) begin
                        att   <= user_att;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (sample_ce) begin
                        if (cnt == STEP_LAST) begin
                            cnt <= '0;
                            att <= att - 5'd1;
                            if ((att - 5'd1) == user_att) begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE) || pending;

    assign flt_rate = active[31:0];
    assign cx       = active[71:32];
    assign cx0      = active[79:72];
    assign cx1      = active[87:80];
    assign cx2      = active[95:88];
    assign cy0      = active[119:96];
    assign cy1      = active[143:120];
    assign cy2      = active[167:144];

endmodule
